wb_burst_ram_slave: RTL and testbench

Wishbone B3 responder with an internal word-addressed RAM. It answers the classic and incrementing-burst cycles issued by the DSP block's Wishbone master port, so that port can be exercised and loaded standalone on a small interconnect. Classic cycles support programmable wait states; incrementing bursts support linear and wrap-4/8/16 addressing. Out-of-range accesses are terminated with an error.

---
 rtl/wb_burst_ram_slave.sv | 195 +++++++++++++++++++
 tb/tb_wb_burst_ram_slave.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_burst_ram_slave.sv
// Wishbone B3 RAM responder: classic cycles with programmable wait states,
// incrementing bursts with linear and wrap-4/8/16 addressing, error on out-of-range.
module wb_burst_ram_slave #(
    parameter int unsigned   dw           = 32,
    parameter int unsigned   aw           = 32,
    parameter logic [aw-1:0] BASE_ADDRESS = '0,
    parameter int unsigned   MEM_WORDS    = 256,
    parameter int unsigned   WAIT_STATES  = 0
) (
    input  logic              wb_clk,
    input  logic              wb_rst,
    input  logic [aw-1:0]     wb_adr_i,
    input  logic [dw-1:0]     wb_dat_i,
    input  logic [dw/8-1:0]   wb_sel_i,
    input  logic              wb_we_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic [2:0]        wb_cti_i,
    input  logic [1:0]        wb_bte_i,
    output logic [dw-1:0]     wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic              wb_rty_o
);

    localparam int unsigned IW       = $clog2(MEM_WORDS);
    localparam int unsigned IW1      = IW + 1;
    localparam int unsigned NB       = dw / 8;
    localparam logic [3:0]  WS       = 4'(WAIT_STATES);
    localparam logic [2:0]  CTI_INCR = 3'b010;
    localparam logic [2:0]  CTI_END  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_BURST
    } state_e;

    logic [dw-1:0] mem [MEM_WORDS];

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          hit_q, hit_d;
    logic          we_q, we_d;
    logic [1:0]    bte_q, bte_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;

    logic [aw-1:0] off_c;
    logic          adr_hit_c;
    logic [IW-1:0] adr_idx_c;
    logic [IW:0]   lin_c;
    logic [IW-1:0] inc_c;
    logic [IW-1:0] wmask_c;
    logic [IW-1:0] nxt_idx_c;
    logic          nxt_miss_c;
    logic          wr_en_c;

    // Word index of the incoming address relative to the RAM window
    assign off_c     = wb_adr_i - BASE_ADDRESS;
    assign adr_hit_c = (off_c >> (IW + 2)) == '0;
    assign adr_idx_c = off_c[IW+1:2];

    // Next burst index: linear carries out of the window, wrap keeps upper bits
    always_comb begin
        lin_c      = {1'b0, idx_q} + IW1'(1);
        inc_c      = idx_q + IW'(1);
        wmask_c    = '0;
        nxt_idx_c  = lin_c[IW-1:0];
        nxt_miss_c = lin_c[IW];
        case (bte_q)
            2'b01:   wmask_c = IW'(3);
            2'b10:   wmask_c = IW'(7);
            2'b11:   wmask_c = IW'(15);
            default: wmask_c = '0;
        endcase
        if (bte_q != 2'b00) begin
            nxt_idx_c  = (idx_q & ~wmask_c) | (inc_c & wmask_c);
            nxt_miss_c = 1'b0;
        end
    end

    // Access sequencing and response generation
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hit_d   = hit_q;
        we_d    = we_q;
        bte_d   = bte_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    idx_d = adr_idx_c;
                    hit_d = adr_hit_c;
                    we_d  = wb_we_i;
                    bte_d = wb_bte_i;
                    cnt_d = WS;
                    if (WS != 4'd0) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_RESP;
                        ack_d   = adr_hit_c;
                        err_d   = !adr_hit_c;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (!wb_cyc_i) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_d == 4'd0) begin
                    state_d = S_RESP;
                    ack_d   = hit_q;
                    err_d   = !hit_q;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                if (wb_cyc_i && wb_stb_i && hit_q && wb_cti_i == CTI_INCR) begin
                    idx_d = nxt_idx_c;
                    if (nxt_miss_c) begin
                        state_d = S_RESP;
                        hit_d   = 1'b0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_BURST;
                        ack_d   = 1'b1;
                    end
                end
            end
            S_BURST: begin
                state_d = S_IDLE;
                if (wb_cyc_i && wb_stb_i && wb_cti_i != CTI_END) begin
                    idx_d = nxt_idx_c;
                    if (nxt_miss_c) begin
                        state_d = S_RESP;
                        hit_d   = 1'b0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_BURST;
                        ack_d   = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            hit_q   <= 1'b0;
            we_q    <= 1'b0;
            bte_q   <= 2'b00;
            cnt_q   <= 4'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hit_q   <= hit_d;
            we_q    <= we_d;
            bte_q   <= bte_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // A beat's write lands on the edge that closes its ack cycle
    assign wr_en_c = ack_q && wb_cyc_i && wb_stb_i && we_q;

    always_ff @(posedge wb_clk) begin
        if (wr_en_c) begin
            for (int b = 0; b < NB; b++) begin
                if (wb_sel_i[b]) begin
                    mem[idx_q][8*b +: 8] <= wb_dat_i[8*b +: 8];
                end
            end
        end
    end

    assign wb_dat_o = ack_q ? mem[idx_q] : '0;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_rty_o = 1'b0;

endmodule

// File: tb/tb_wb_burst_ram_slave.sv
// Bench for wb_burst_ram_slave: two instances (0 and 3 wait states) driven by a
// Wishbone master model and checked against an array-based memory reference.
module tb_wb_burst_ram_slave;

    localparam int unsigned MW   = 256;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          WS3  = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] adr = '0;
    logic [31:0] wdat = '0;
    logic [3:0]  sel = '0;
    logic        we = 1'b0;
    logic [2:0]  cti = '0;
    logic [1:0]  bte = '0;
    logic        cyc0 = 1'b0, stb0 = 1'b0, cyc3 = 1'b0, stb3 = 1'b0;
    logic [31:0] dat0, dat3;
    logic        ack0, ack3, err0, err3, rty0, rty3;
    logic        cur = 1'b0;
    logic        ack_m, err_m;
    logic [31:0] dat_m;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [2][MW];
    logic        vld   [2][MW];
    logic [31:0] bq    [16];

    always #5 clk = ~clk;

    assign ack_m = cur ? ack3 : ack0;
    assign err_m = cur ? err3 : err0;
    assign dat_m = cur ? dat3 : dat0;

    wb_burst_ram_slave #(.dw(32), .aw(32), .BASE_ADDRESS(BASE), .MEM_WORDS(MW), .WAIT_STATES(0)) u_dut0 (
        .wb_clk(clk), .wb_rst(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
        .wb_we_i(we), .wb_cyc_i(cyc0), .wb_stb_i(stb0), .wb_cti_i(cti), .wb_bte_i(bte),
        .wb_dat_o(dat0), .wb_ack_o(ack0), .wb_err_o(err0), .wb_rty_o(rty0));

    wb_burst_ram_slave #(.dw(32), .aw(32), .BASE_ADDRESS(BASE), .MEM_WORDS(MW), .WAIT_STATES(WS3)) u_dut3 (
        .wb_clk(clk), .wb_rst(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
        .wb_we_i(we), .wb_cyc_i(cyc3), .wb_stb_i(stb3), .wb_cti_i(cti), .wb_bte_i(bte),
        .wb_dat_o(dat3), .wb_ack_o(ack3), .wb_err_o(err3), .wb_rty_o(rty3));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cs(input logic c, input logic s);
        if (cur) begin cyc3 = c; stb3 = s; end
        else     begin cyc0 = c; stb0 = s; end
    endtask

    function automatic int ws_of(input logic d);
        return d ? WS3 : 0;
    endfunction

    function automatic void mwrite(input logic d, input int i, input logic [31:0] v, input logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) model[d][i][8*b +: 8] = v[8*b +: 8];
        if (s == 4'hF) vld[d][i] = 1'b1;
    endfunction

    // Single classic access; the model decides hit/miss from the byte offset
    task automatic classic(input logic d, input logic w, input logic [31:0] a, input logic [31:0] dat,
                           input logic [3:0] s, output logic [31:0] rd, output logic got_err);
        logic [31:0] off;
        logic        hit;
        int          i, lat;
        off = a - BASE;
        hit = off < MW * 4;
        i   = int'(off >> 2);
        cur = d; adr = a; we = w; wdat = dat; sel = s;
        bte = 2'($urandom_range(0, 3));
        cti = 3'($urandom_range(0, 1));
        set_cs(1'b1, 1'b1);
        lat = 0;
        do begin tick(); lat++; end while (!(ack_m || err_m) && lat < 40);
        chk("classic latency", 32'(lat), 32'(1 + ws_of(d)));
        chk("classic ack", 32'(ack_m), 32'(hit));
        chk("classic err", 32'(err_m), 32'(!hit));
        rd = dat_m;
        got_err = err_m;
        if (hit) begin
            if (vld[d][i]) chk("classic dat_o", dat_m, model[d][i]);
            if (w) mwrite(d, i, dat, s);
        end else begin
            chk("classic dat_o on err", dat_m, 32'h0);
        end
        tick();
        chk("classic ack/err drop", 32'({ack_m, err_m}), 32'h0);
        set_cs(1'b0, 1'b0);
    endtask

    // Incrementing burst of n beats; expected addresses from modular arithmetic
    task automatic burst(input logic d, input int i0, input logic [1:0] b, input int n, input logic w);
        int          nw, lat;
        int          ik [16];
        logic [31:0] data [16];
        logic [3:0]  s [16];
        logic        hit;
        nw = (b == 2'b00) ? 0 : (2 << b);
        for (int k = 0; k < n; k++) begin
            ik[k]   = (nw == 0) ? i0 + k : (i0 / nw) * nw + (i0 + k) % nw;
            data[k] = $urandom;
            s[k]    = 4'($urandom_range(0, 15));
        end
        cur = d; we = w; bte = b;
        adr  = BASE + 32'(ik[0]) * 4;
        cti  = (n == 1) ? 3'b111 : 3'b010;
        wdat = data[0]; sel = s[0];
        set_cs(1'b1, 1'b1);
        lat = 0;
        do begin tick(); lat++; end while (!(ack_m || err_m) && lat < 40);
        chk("burst first latency", 32'(lat), 32'(1 + ws_of(d)));
        for (int k = 0; k < n; k++) begin
            hit = ik[k] < MW;
            chk("burst ack", 32'(ack_m), 32'(hit));
            chk("burst err", 32'(err_m), 32'(!hit));
            if (hit) begin
                if (vld[d][ik[k]]) chk("burst dat_o", dat_m, model[d][ik[k]]);
                bq[k] = dat_m;
                if (w) mwrite(d, ik[k], data[k], s[k]);
            end else begin
                chk("burst dat_o on err", dat_m, 32'h0);
            end
            if (!hit || k == n - 1) break;
            tick();
            adr  = BASE + 32'(ik[k+1]) * 4;
            wdat = data[k+1]; sel = s[k+1];
            cti  = (k + 1 == n - 1) ? 3'b111 : 3'b010;
        end
        tick();
        chk("burst end ack/err low", 32'({ack_m, err_m}), 32'h0);
        set_cs(1'b0, 1'b0);
        cti = 3'b000;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        exp_err;
        logic        chk_dat;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [31:0] rd;
        logic        ge;

        tbl[0]  = '{1'b1, 32'h0000_1010, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 32'h0000_1010, 32'h0,         4'hF, 1'b0, 1'b1, 32'hDEAD_BEEF};
        tbl[2]  = '{1'b1, 32'h0000_1020, 32'h1122_3344, 4'hF, 1'b0, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 32'h0000_1020, 32'hAABB_CCDD, 4'h5, 1'b0, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 32'h0000_1020, 32'h0,         4'hF, 1'b0, 1'b1, 32'h11BB_33DD};
        tbl[5]  = '{1'b0, 32'h0000_1400, 32'h0,         4'hF, 1'b1, 1'b1, 32'h0};
        tbl[6]  = '{1'b1, 32'h0000_0FFC, 32'h1234_5678, 4'hF, 1'b1, 1'b1, 32'h0};
        tbl[7]  = '{1'b1, 32'h0000_13FC, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0, 32'h0};
        tbl[8]  = '{1'b0, 32'h0000_13FE, 32'h0,         4'hF, 1'b0, 1'b1, 32'hCAFE_F00D};
        tbl[9]  = '{1'b1, 32'h0000_13FC, 32'hFFFF_FFFF, 4'h0, 1'b0, 1'b0, 32'h0};
        tbl[10] = '{1'b0, 32'h0000_13FC, 32'h0,         4'hF, 1'b0, 1'b1, 32'hCAFE_F00D};
        tbl[11] = '{1'b0, 32'h0000_0000, 32'h0,         4'hF, 1'b1, 1'b1, 32'h0};
        tbl[12] = '{1'b1, 32'h0000_1400, 32'h5A5A_5A5A, 4'hF, 1'b1, 1'b1, 32'h0};
        tbl[13] = '{1'b0, 32'h0000_1000, 32'h0,         4'hF, 1'b0, 1'b1, 32'h0};

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < MW; i++) begin
                vld[d][i]   = 1'b0;
                model[d][i] = '0;
            end

        // Reset state
        #2 rst_n = 1'b0;
        #10;
        chk("reset ack0", 32'(ack0), 0); chk("reset err0", 32'(err0), 0);
        chk("reset dat0", dat0, 0);      chk("reset rty0", 32'(rty0), 0);
        chk("reset ack3", 32'(ack3), 0); chk("reset err3", 32'(err3), 0);
        chk("reset dat3", dat3, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick();

        // Preload mem[i] = i in both instances
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < MW; i++)
                classic(1'(d), 1'b1, BASE + 32'(i) * 4, 32'(i), 4'hF, rd, ge);

        // Wrap4 read from index 6
        burst(1'b0, 6, 2'b01, 4, 1'b0);
        chk("wrap4 beat0", bq[0], 32'd6); chk("wrap4 beat1", bq[1], 32'd7);
        chk("wrap4 beat2", bq[2], 32'd4); chk("wrap4 beat3", bq[3], 32'd5);

        // Wait-state read, three idle cycles before ack
        classic(1'b1, 1'b0, BASE + 32'h40, 32'h0, 4'hF, rd, ge);
        chk("ws3 read data", rd, 32'd16);

        // Linear write running off the end of the window
        burst(1'b0, MW - 2, 2'b00, 3, 1'b1);
        classic(1'b0, 1'b0, BASE, 32'h0, 4'hF, rd, ge);
        chk("mem0 unchanged", rd, 32'h0);

        for (int i = 0; i < 14; i++) begin
            classic(1'b0, tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, rd, ge);
            chk($sformatf("vec%0d err", i), 32'(ge), 32'(tbl[i].exp_err));
            if (tbl[i].chk_dat) chk($sformatf("vec%0d data", i), rd, tbl[i].exp_dat);
        end

        // Abort: cyc dropped during beat 2 of an 8-beat linear write
        cur = 1'b0; adr = BASE + 32'd400; we = 1'b1; bte = 2'b00; cti = 3'b010;
        wdat = 32'hA000_0000; sel = 4'hF;
        set_cs(1'b1, 1'b1);
        tick();
        chk("abort beat1 ack", 32'(ack0), 1);
        tick();
        chk("abort beat2 ack", 32'(ack0), 1);
        set_cs(1'b0, 1'b0);
        wdat = 32'hA000_0001;
        tick();
        chk("abort ack/err low", 32'({ack0, err0}), 0);
        mwrite(1'b0, 100, 32'hA000_0000, 4'hF);
        cti = 3'b000;
        classic(1'b0, 1'b0, BASE + 32'd400, 32'h0, 4'hF, rd, ge);
        chk("abort beat1 written", rd, 32'hA000_0000);
        classic(1'b0, 1'b0, BASE + 32'd404, 32'h0, 4'hF, rd, ge);
        chk("abort beat2 not written", rd, 32'd101);

        // Reset during an ack cycle drops outputs at once
        cur = 1'b0; adr = BASE + 32'h80; we = 1'b0; sel = 4'hF;
        set_cs(1'b1, 1'b1);
        tick();
        chk("pre-reset ack", 32'(ack0), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset ack", 32'(ack0), 0);
        chk("async reset dat", dat0, 0);
        set_cs(1'b0, 1'b0);
        tick(); rst_n = 1'b1; tick();

        // Reset during WAIT loses the pending write
        cur = 1'b1; adr = BASE + 32'd200; we = 1'b1; wdat = 32'h5555_AAAA; sel = 4'hF;
        set_cs(1'b1, 1'b1);
        tick(); tick();
        chk("wait no ack", 32'({ack3, err3}), 0);
        rst_n = 1'b0;
        #1;
        chk("wait reset outputs", 32'({ack3, err3}), 0);
        chk("wait reset dat", dat3, 0);
        set_cs(1'b0, 1'b0);
        tick(); rst_n = 1'b1; tick();
        classic(1'b1, 1'b0, BASE + 32'd200, 32'h0, 4'hF, rd, ge);
        chk("write lost on reset", rd, 32'd50);

        // Randomized traffic against the model
        for (int it = 0; it < 80; it++) begin
            logic        d, w;
            int          r;
            logic [31:0] a;
            logic [1:0]  b;
            int          n, i0;
            d = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) begin
                r = $urandom_range(0, 9);
                if (r < 6)      a = BASE + 32'($urandom_range(0, MW - 1)) * 4 + 32'($urandom_range(0, 3));
                else if (r < 7) a = BASE + MW * 4 + 32'($urandom_range(0, 15)) * 4;
                else if (r < 8) a = BASE - 32'($urandom_range(1, 16)) * 4;
                else            a = $urandom;
                classic(d, w, a, $urandom, 4'($urandom_range(0, 15)), rd, ge);
            end else begin
                b  = 2'($urandom_range(0, 3));
                n  = (b == 2'b00) ? $urandom_range(1, 8) : $urandom_range(1, 2 << b);
                i0 = ($urandom_range(0, 9) < 3) ? $urandom_range(MW - 4, MW) : $urandom_range(0, MW - 1);
                burst(d, i0, b, n, w);
            end
        end

        chk("rty0 tied low", 32'(rty0), 0);
        chk("rty3 tied low", 32'(rty3), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
